// File: rtl/gtp_pll_reset_seq.sv
// Purpose: reset/lock sequencer for the PLL0 of a GTPE2_COMMON; qualifies the PLL clock and raises ready.
// Latency: status inputs act 2 clk after they change (2-FF sync); all outputs registered, valid at the edge a state is entered.
// Backpressure: none; start is a one-cycle request honoured only in IDLE/FAIL and ignored while sequencing.
//
// Ports:
//   clk          free-running system/DRP clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle request to begin or restart sequencing
//   pll_lock     PLL0LOCK (asynchronous to clk)
//   refclk_lost  PLL0REFCLKLOST (asynchronous to clk)
//   pll_pd       drives PLL0PD
//   pll_reset    drives PLL0RESET
//   ready        PLL locked and stable
//   fail         sticky: lock retries exhausted
//   retry_cnt    timeout retries used in the current attempt
//   state_o      encoded state for debug
module gtp_pll_reset_seq #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 64,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 16,
    localparam int RETRY_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pll_lock,
    input  logic               refclk_lost,
    output logic               pll_pd,
    output logic               pll_reset,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_READY     = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry, retry_nxt;
    logic               lock_meta, lock_s;
    logic               lost_meta, lost_s;
    logic               pd_nxt, rst_nxt, ready_nxt, fail_nxt;

    // Both status pins come from the PLL domain; only the second stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            lost_meta <= 1'b0;
            lost_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            lost_meta <= refclk_lost;
            lost_s    <= lost_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            ST_RESET: begin
                // A lost reference clock restarts the pulse so the PLL always
                // sees a full reset width after the refclk comes back.
                if (lost_s) begin
                    cnt_nxt = '0;
                end else if (cnt == RESET_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lost_s) begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = '0;
                end else if (lock_s) begin
                    // Checked ahead of the timeout so a lock on the last cycle wins.
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt = '0;
                    if (retry < RETRY_MAX) begin
                        state_nxt = ST_RESET;
                        retry_nxt = retry + 1'b1;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_STABLE: begin
                if (lost_s) begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = '0;
                end else if (!lock_s) begin
                    // A lock glitch is not a timeout: the wait restarts, retries untouched.
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_READY: begin
                if (lost_s) begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = '0;
                end else if (!lock_s) begin
                    // Losing lock after being ready counts as a brand new attempt.
                    state_nxt = ST_RESET;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            ST_FAIL: begin
                if (start) begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                retry_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the state being entered and registered with it.
    always_comb begin
        pd_nxt    = (state_nxt == ST_IDLE) || (state_nxt == ST_FAIL);
        rst_nxt   = (state_nxt == ST_IDLE) || (state_nxt == ST_RESET) || (state_nxt == ST_FAIL);
        ready_nxt = (state_nxt == ST_READY);
        fail_nxt  = (state_nxt == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            retry     <= '0;
            pll_pd    <= 1'b1;
            pll_reset <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry     <= retry_nxt;
            pll_pd    <= pd_nxt;
            pll_reset <= rst_nxt;
            ready     <= ready_nxt;
            fail      <= fail_nxt;
        end
    end

    assign state_o   = state;
    assign retry_cnt = retry;

endmodule

// File: tb/tb_gtp_pll_reset_seq.sv
// Purpose: self-checking bench for gtp_pll_reset_seq (default parameters).
// Latency: directed timing checks plus a per-cycle compare against a reference model.
// Backpressure: not applicable; inputs driven on the falling edge, outputs sampled there too.
`timescale 1ns/1ps
module tb_gtp_pll_reset_seq;

    localparam int RC = 16;
    localparam int LT = 4096;
    localparam int LS = 64;
    localparam int MR = 3;
    localparam int ATTEMPT = RC + LT;

    // Spec state codes.
    localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_STABLE = 3, P_READY = 4, P_FAIL = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pll_lock = 1'b0;
    logic       refclk_lost = 1'b0;
    logic       pll_pd, pll_reset, ready, fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    gtp_pll_reset_seq #(
        .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS),
        .MAX_RETRIES(MR), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pll_lock(pll_lock),
        .refclk_lost(refclk_lost), .pll_pd(pll_pd), .pll_reset(pll_reset),
        .ready(ready), .fail(fail), .retry_cnt(retry_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: phase plus the edge number at which the current timed
    // interval started; intervals end when (edge - mark) hits the spec length.
    int m_ph, m_mark, m_retry;
    bit m_lk0, m_lk1, m_lo0, m_lo1;

    task automatic model_reset();
        m_ph = P_IDLE; m_mark = 0; m_retry = 0;
        m_lk0 = 0; m_lk1 = 0; m_lo0 = 0; m_lo1 = 0;
    endtask

    task automatic goto_ph(input int ph);
        m_ph = ph;
        m_mark = cyc;
    endtask

    task automatic model_step();
        bit ls, lo;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // Inputs seen by the sequencer are those sampled two edges earlier.
        ls = m_lk1; lo = m_lo1;
        m_lk1 = m_lk0; m_lk0 = pll_lock;
        m_lo1 = m_lo0; m_lo0 = refclk_lost;
        case (m_ph)
            P_IDLE:  if (start) begin goto_ph(P_RESET); m_retry = 0; end
            P_RESET: begin
                if (lo) m_mark = cyc;
                else if (cyc - m_mark == RC) goto_ph(P_WAIT);
            end
            P_WAIT: begin
                if (lo) goto_ph(P_RESET);
                else if (ls) goto_ph(P_STABLE);
                else if (cyc - m_mark == LT) begin
                    if (m_retry < MR) begin m_retry++; goto_ph(P_RESET); end
                    else goto_ph(P_FAIL);
                end
            end
            P_STABLE: begin
                if (lo) goto_ph(P_RESET);
                else if (!ls) goto_ph(P_WAIT);
                else if (cyc - m_mark == LS) goto_ph(P_READY);
            end
            P_READY: begin
                if (lo) goto_ph(P_RESET);
                else if (!ls) begin goto_ph(P_RESET); m_retry = 0; end
            end
            P_FAIL: if (start) begin goto_ph(P_RESET); m_retry = 0; end
            default: model_reset();
        endcase
    endtask

    function automatic logic [31:0] exp_vec();
        logic pd, rs, rdy, fl;
        pd  = (m_ph == P_IDLE) || (m_ph == P_FAIL);
        rs  = (m_ph == P_IDLE) || (m_ph == P_RESET) || (m_ph == P_FAIL);
        rdy = (m_ph == P_READY);
        fl  = (m_ph == P_FAIL);
        return {23'd0, 3'(m_ph), pd, rs, rdy, fl, 2'(m_retry)};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {23'd0, state_o, pll_pd, pll_reset, ready, fail, retry_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        chk("cycle_vs_model", obs_vec(), exp_vec());
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    int e0, l0, l2, w0;

    initial begin
        model_reset();
        // Reset state
        repeat (3) tick();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_pd", 32'(pll_pd), 1);
        chk("rst_pll_reset", 32'(pll_reset), 1);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_no_start", 32'(state_o), P_IDLE);

        // Nominal lock
        start = 1'b1; tick(); start = 1'b0; e0 = cyc;
        chk("nom_enter_reset", 32'(state_o), P_RESET);
        run_to(e0 + 15); chk("nom_reset_hi_end", 32'(pll_reset), 1);
        run_to(e0 + 16); chk("nom_reset_lo", 32'(pll_reset), 0);
        chk("nom_wait", 32'(state_o), P_WAIT);
        run_to(e0 + 29); pll_lock = 1'b1;
        run_to(e0 + 31); chk("nom_still_wait", 32'(state_o), P_WAIT);
        run_to(e0 + 32); chk("nom_stable", 32'(state_o), P_STABLE);
        run_to(e0 + 95); chk("nom_not_ready", 32'(ready), 0);
        run_to(e0 + 96); chk("nom_ready", 32'(ready), 1);
        chk("nom_retry", 32'(retry_cnt), 0);

        // Loss of lock in READY, then relock
        run_to(e0 + 110); pll_lock = 1'b0; l0 = cyc + 1;
        run_to(l0 + 1); chk("loss_ready_held", 32'(ready), 1);
        run_to(l0 + 2); chk("loss_ready_drop", 32'(ready), 0);
        chk("loss_state", 32'(state_o), P_RESET);
        pll_lock = 1'b1;
        run_to(l0 + 17); chk("loss_pulse_hi", 32'(pll_reset), 1);
        run_to(l0 + 18); chk("loss_pulse_lo", 32'(pll_reset), 0);
        run_to(l0 + 19); chk("loss_restable", 32'(state_o), P_STABLE);

        // One-cycle lock glitch in STABLE
        run_to(l0 + 29); pll_lock = 1'b0; tick(); pll_lock = 1'b1;
        run_to(l0 + 32); chk("glitch_wait", 32'(state_o), P_WAIT);
        run_to(l0 + 33); chk("glitch_stable", 32'(state_o), P_STABLE);
        chk("glitch_retry", 32'(retry_cnt), 0);
        run_to(l0 + 96); chk("glitch_not_ready", 32'(ready), 0);
        run_to(l0 + 97); chk("glitch_ready", 32'(ready), 1);

        // refclk_lost for 100 cycles during WAIT_LOCK
        pll_lock = 1'b0; l2 = cyc + 1;
        run_to(l2 + 18); chk("lost_in_wait", 32'(state_o), P_WAIT);
        run_to(l2 + 24); refclk_lost = 1'b1; w0 = cyc + 1;
        run_to(w0 + 1); chk("lost_sync_delay", 32'(state_o), P_WAIT);
        run_to(w0 + 2); chk("lost_reset", 32'(state_o), P_RESET);
        chk("lost_pulse_start", 32'(pll_reset), 1);
        run_to(w0 + 60); chk("lost_pulse_mid", 32'(pll_reset), 1);
        run_to(w0 + 99); refclk_lost = 1'b0;
        run_to(w0 + 116); chk("lost_pulse_tail", 32'(pll_reset), 1);
        run_to(w0 + 117); chk("lost_release", 32'(state_o), P_WAIT);

        // Asynchronous reset mid-STABLE
        pll_lock = 1'b1;
        run_to(w0 + 140); chk("ar_stable", 32'(state_o), P_STABLE);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_state", 32'(state_o), P_IDLE);
        chk("ar_pd", 32'(pll_pd), 1);
        chk("ar_pll_reset", 32'(pll_reset), 1);
        chk("ar_ready", 32'(ready), 0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) tick();
        chk("ar_needs_start", 32'(state_o), P_IDLE);

        // No lock: retries then FAIL
        pll_lock = 1'b0;
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0; e0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            run_to(e0 + k * ATTEMPT - 1); chk("nl_waiting", 32'(state_o), P_WAIT);
            run_to(e0 + k * ATTEMPT);     chk("nl_retry_state", 32'(state_o), P_RESET);
            chk("nl_retry_cnt", 32'(retry_cnt), 32'(k));
            run_to(e0 + k * ATTEMPT + 15); chk("nl_pulse_hi", 32'(pll_reset), 1);
            run_to(e0 + k * ATTEMPT + 16); chk("nl_pulse_end", 32'(state_o), P_WAIT);
        end
        run_to(e0 + 4 * ATTEMPT - 1); chk("nl_pre_fail", 32'(fail), 0);
        run_to(e0 + 4 * ATTEMPT);
        chk("nl_fail_state", 32'(state_o), P_FAIL);
        chk("nl_fail_flag", 32'(fail), 1);
        chk("nl_fail_pd", 32'(pll_pd), 1);
        chk("nl_fail_retry", 32'(retry_cnt), 3);
        repeat (10) tick();
        chk("nl_fail_sticky", 32'(fail), 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("nl_restart_state", 32'(state_o), P_RESET);
        chk("nl_restart_fail", 32'(fail), 0);
        chk("nl_restart_retry", 32'(retry_cnt), 0);

        // Randomized stimulus, checked every cycle against the model
        for (int seg = 0; seg < 400 && cyc < 85000; seg++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                start = 1'b1; tick(); start = 1'b0;
            end else if (r < 14) begin
                refclk_lost = 1'b1;
                repeat ($urandom_range(1, 30)) tick();
                refclk_lost = 1'b0;
            end else if (r < 16) begin
                pll_lock = 1'b0;
                repeat (LT + $urandom_range(0, 200)) tick();
            end else if (r < 40) begin
                pll_lock = ~pll_lock;
                repeat ($urandom_range(1, 3)) tick();
                pll_lock = ~pll_lock;
            end else begin
                pll_lock = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 120)) tick();
            end
        end
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gtp_pll_reset_seq.md
Name: gtp_pll_reset_seq

Overview:
- Reset/lock sequencer that drives the PLL0 control pins of a GTPE2_COMMON and consumes its PLL0LOCK and REFCLK-lost status.
- Sits directly downstream of the common block: it qualifies the PLL output clock as usable and releases `ready` to the channel-reset logic.
- Handles power-up, timed reset pulse, lock-timeout retries, lock debouncing, and recovery from loss of lock or loss of reference clock.

Parameters:
- RESET_CYCLES, 16: number of clk cycles `pll_reset` is held in the RESET state (min 1).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry (min 1).
- LOCK_STABLE, 64: consecutive synchronized-lock cycles required before `ready` (min 1).
- MAX_RETRIES, 3: timeout-driven retries before FAIL (min 0).
- CNT_W, 16: cycle-counter width; must hold max(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE).

Ports:
- clk, input, 1: sole clock, free-running DRP/system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle request to begin or restart sequencing.
- pll_lock, input, 1: PLL0LOCK from GTPE2_COMMON; asynchronous to clk.
- refclk_lost, input, 1: PLL0REFCLKLOST; asynchronous to clk.
- pll_pd, output, 1: to PLL0PD.
- pll_reset, output, 1: to PLL0RESET.
- ready, output, 1: PLL locked and stable.
- fail, output, 1: sticky retry exhaustion.
- retry_cnt, output, $clog2(MAX_RETRIES+1) (min 1): retries used in the current attempt.
- state_o, output, 3: encoded state, for debug.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (`rst_n`). All flops clear asynchronously when `rst_n` is low.
- Reset values: state = IDLE; `pll_pd` = 1; `pll_reset` = 1; `ready` = 0; `fail` = 0; `retry_cnt` = 0; counter = 0; synchronizers = 0.
- Synchronization: `pll_lock` and `refclk_lost` each pass through a 2-FF synchronizer, giving lock_s and lost_s. The FSM uses only the synchronized values, so an input change is visible 2 cycles later.
- Outputs: all registered. Each output reflects the state entered at the same edge.
- State encoding (`state_o`): IDLE = 0, RESET = 1, WAIT_LOCK = 2, STABLE = 3, READY = 4, FAIL = 5.
- IDLE:
  - `pll_pd` = 1, `pll_reset` = 1.
  - `start` = 1 → RESET; counter = 0; `retry_cnt` = 0.
- RESET:
  - `pll_pd` = 0, `pll_reset` = 1.
  - Counter increments each cycle while lost_s = 0.
  - While lost_s = 1, the counter is held at 0.
  - When the counter reaches RESET_CYCLES-1 with lost_s = 0 → WAIT_LOCK; counter = 0.
  - Net effect: `pll_reset` is high for exactly RESET_CYCLES cycles after the last lost_s = 1 cycle.
- WAIT_LOCK:
  - `pll_reset` = 0.
  - lock_s = 1 → STABLE; counter = 0.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1:
    - if `retry_cnt` < MAX_RETRIES → `retry_cnt`++ and go to RESET;
    - else → FAIL.
  - If lock_s = 1 arrives on the timeout cycle, lock wins.
- STABLE:
  - lock_s = 0 → WAIT_LOCK; counter = 0. The timeout restarts and `retry_cnt` is unchanged.
  - When the counter reaches LOCK_STABLE-1 with lock_s = 1 → READY; `ready` = 1.
- READY:
  - `ready` = 1.
  - lock_s = 0 → RESET; `ready` = 0 at the same edge; `retry_cnt` = 0 (fresh attempt).
- FAIL:
  - `fail` = 1, `pll_pd` = 1, `pll_reset` = 1, `ready` = 0.
  - `start` → RESET; `fail` = 0; `retry_cnt` = 0.
- refclk_lost: in WAIT_LOCK, STABLE or READY, lost_s = 1 → RESET (`ready` drops). It has priority over every other transition. It is ignored in IDLE and FAIL.
- start: ignored in RESET, WAIT_LOCK, STABLE and READY.
- `retry_cnt` saturates at MAX_RETRIES and never wraps.
- MAX_RETRIES = 0: the first timeout goes directly to FAIL.

Test Plan:
- Nominal lock (defaults):
  - Stimulus: release `rst_n`; pulse `start` at edge E0; drive `pll_lock` = 1 at E0+30.
  - Required: `pll_reset` high E0..E0+16, low from E0+16; STABLE entered at E0+32; `ready` = 1 at E0+96; `retry_cnt` = 0.
- No lock:
  - Stimulus: `pll_lock` held 0 after `start`.
  - Required: 3 further RESET pulses of 16 cycles, each followed by a 4096-cycle wait; `retry_cnt` steps 1, 2, 3; FAIL with `fail` = 1 at E0+4·(16+4096); `pll_pd` = 1.
- Lock glitch in STABLE:
  - Stimulus: drop `pll_lock` for 1 cycle during STABLE.
  - Required: return to WAIT_LOCK, then STABLE again; `ready` only after 64 uninterrupted cycles; `retry_cnt` unchanged.
- Loss of lock in READY:
  - Stimulus: drop `pll_lock` while READY.
  - Required: `ready` = 0 two cycles later; `state_o` = 1; 16-cycle `pll_reset` pulse; relock restores `ready`.
- refclk_lost:
  - Stimulus: assert `refclk_lost` for 100 cycles during WAIT_LOCK.
  - Required: RESET is held with `pll_reset` = 1 throughout and for 16 cycles after lost_s clears.
- Asynchronous reset mid-sequence:
  - Stimulus: pulse `rst_n` low mid-STABLE, not aligned to `clk`.
  - Required: outputs immediately return to IDLE values (`pll_pd` = 1, `pll_reset` = 1, `ready` = 0); `start` is required to resume.
